// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage issue/hazard bus between the pipeline front end and the scoreboard
// Front end (master) drives the decoded ID instruction and flush.
// Scoreboard (slave) returns stall, issue and the registered pending count.
interface hazard_scoreboard_if #(parameter int LAT_W = 3);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_regwrite;
  logic [LAT_W-1:0] id_lat;
  logic             flush;
  logic             stall;
  logic             issue;
  logic [4:0]       pending_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regwrite, id_lat, flush,
    input  stall, issue, pending_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_regwrite, id_lat, flush,
    output stall, issue, pending_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage interlock tracking in-flight register writes until they are forwardable
// Ports: clk, reset (sync, active-high), sb (slave side of hazard_scoreboard_if).
// stall/issue are combinational from state and ID inputs; pending_cnt is registered.
module hazard_scoreboard #(
  parameter int LAT_W        = 3,
  parameter int FLUSH_WINDOW = 2
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave sb
);
  localparam int AW = FLUSH_WINDOW > 0 ? $clog2(FLUSH_WINDOW + 1) : 1;
  logic [LAT_W-1:0] cnt_q [31];
  logic [LAT_W-1:0] cnt_d [31];
  logic [AW-1:0]    age_q [31];
  logic [AW-1:0]    age_d [31];
  logic [4:0]       pending_q;
  logic [4:0]       pending_d;
  logic [LAT_W-1:0] cnt_ext [32];
  logic             raw;
  logic             waw;
  logic             stall;
  logic             issue;
  logic             wr;
  always_comb begin
    // X31 reads as an always-idle entry so it can never match or stall
    cnt_ext = '{default: '0};
    for (int r = 0; r < 31; r++) cnt_ext[r] = cnt_q[r];
    raw = sb.id_valid & ((sb.id_rs1_used & (sb.id_rs1 != 5'd31) & (cnt_ext[sb.id_rs1] != '0)) |
                         (sb.id_rs2_used & (sb.id_rs2 != 5'd31) & (cnt_ext[sb.id_rs2] != '0)));
    // a shorter op may not overtake a longer one to the same destination
    waw = sb.id_valid & sb.id_regwrite & (sb.id_rd != 5'd31) & (cnt_ext[sb.id_rd] > sb.id_lat);
    stall = raw | waw;
    issue = sb.id_valid & ~stall & ~sb.flush;
    wr = issue & sb.id_regwrite & (sb.id_rd != 5'd31) & (sb.id_lat != '0);
    pending_d = '0;
    for (int r = 0; r < 31; r++) begin
      // entries young enough to belong to flushed instructions vanish on flush
      cnt_d[r] = (wr && sb.id_rd == 5'(r)) ? sb.id_lat :
                 (sb.flush && age_q[r] < AW'(FLUSH_WINDOW)) ? '0 :
                 (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      age_d[r] = (wr && sb.id_rd == 5'(r)) ? '0 :
                 (sb.flush && age_q[r] < AW'(FLUSH_WINDOW)) ? '0 :
                 (age_q[r] == AW'(FLUSH_WINDOW)) ? age_q[r] : age_q[r] + AW'(1);
      pending_d = pending_d + 5'(cnt_d[r] != '0);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '{default: '0};
      age_q     <= '{default: '0};
      pending_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      age_q     <= age_d;
      pending_q <= pending_d;
    end
  end
  assign sb.stall       = stall;
  assign sb.issue       = issue;
  assign sb.pending_cnt = pending_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic clk;
  logic reset;
  int checks = 0;
  int passed = 0;
  hazard_scoreboard_if #(.LAT_W(3)) sb ();
  hazard_scoreboard #(.LAT_W(3), .FLUSH_WINDOW(2)) dut (.clk(clk), .reset(reset), .sb(sb));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic set(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                     input logic u2, input logic [4:0] rd, input logic rw, input logic [2:0] lat,
                     input logic fl);
    sb.id_valid = v;
    sb.id_rs1 = r1;
    sb.id_rs1_used = u1;
    sb.id_rs2 = r2;
    sb.id_rs2_used = u2;
    sb.id_rd = rd;
    sb.id_regwrite = rw;
    sb.id_lat = lat;
    sb.flush = fl;
    #2;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  initial begin
    reset = 1'b1;
    set(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rst_stall", 32'(sb.stall), 0);
    chk("rst_issue", 32'(sb.issue), 1);
    chk("rst_pending", 32'(sb.pending_cnt), 0);
    step();
    reset = 1'b0;
    set(1, 0, 0, 0, 0, 5, 1, 0, 0);
    chk("alu_stall", 32'(sb.stall), 0);
    chk("alu_issue", 32'(sb.issue), 1);
    step();
    set(1, 5, 1, 5, 1, 6, 0, 0, 0);
    chk("alu_use_stall", 32'(sb.stall), 0);
    chk("alu_use_pending", 32'(sb.pending_cnt), 0);
    step();
    set(1, 0, 0, 0, 0, 3, 1, 1, 0);
    chk("ld_issue", 32'(sb.issue), 1);
    step();
    set(1, 3, 1, 0, 0, 10, 1, 0, 0);
    chk("ld_use_stall", 32'(sb.stall), 1);
    chk("ld_use_issue", 32'(sb.issue), 0);
    chk("ld_pending1", 32'(sb.pending_cnt), 1);
    step();
    chk("ld_use_stall2", 32'(sb.stall), 0);
    chk("ld_use_issue2", 32'(sb.issue), 1);
    chk("ld_pending0", 32'(sb.pending_cnt), 0);
    step();
    set(1, 0, 0, 0, 0, 7, 1, 4, 0);
    step();
    set(1, 8, 1, 0, 0, 11, 1, 0, 0);
    chk("indep_x8_stall", 32'(sb.stall), 0);
    chk("indep_x8_issue", 32'(sb.issue), 1);
    chk("mul_pending", 32'(sb.pending_cnt), 1);
    step();
    set(1, 0, 0, 7, 0, 0, 0, 0, 0);
    chk("rs2_unused_stall", 32'(sb.stall), 0);
    step();
    set(1, 0, 0, 7, 1, 12, 1, 0, 0);
    chk("mul_use_stall_c2", 32'(sb.stall), 1);
    step();
    chk("mul_use_stall_c1", 32'(sb.stall), 1);
    chk("mul_pending_c1", 32'(sb.pending_cnt), 1);
    step();
    chk("mul_use_issue", 32'(sb.issue), 1);
    chk("mul_pending_0", 32'(sb.pending_cnt), 0);
    step();
    set(1, 0, 0, 0, 0, 9, 1, 4, 0);
    step();
    set(1, 0, 0, 0, 0, 9, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("waw_alu_stall", 32'(sb.stall), 1);
      step();
    end
    chk("waw_alu_issue", 32'(sb.issue), 1);
    step();
    set(1, 0, 0, 0, 0, 9, 1, 4, 0);
    step();
    set(1, 0, 0, 0, 0, 9, 1, 4, 0);
    chk("waw_eq_lat_stall", 32'(sb.stall), 0);
    chk("waw_eq_lat_issue", 32'(sb.issue), 1);
    step();
    set(1, 0, 0, 0, 0, 9, 1, 2, 0);
    chk("waw_short_stall", 32'(sb.stall), 1);
    set(1, 0, 0, 0, 0, 9, 1, 5, 0);
    chk("waw_long_stall", 32'(sb.stall), 0);
    step();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("waw_long_pending", 32'(sb.pending_cnt), 1);
    repeat (5) step();
    chk("waw_drained", 32'(sb.pending_cnt), 0);
    set(1, 0, 0, 0, 0, 4, 1, 7, 0);
    step();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    set(1, 0, 0, 0, 0, 2, 1, 3, 0);
    chk("ld_x2_issue", 32'(sb.issue), 1);
    step();
    set(1, 2, 1, 0, 0, 0, 0, 0, 1);
    chk("flush_stall", 32'(sb.stall), 1);
    chk("flush_issue", 32'(sb.issue), 0);
    chk("flush_pending_pre", 32'(sb.pending_cnt), 2);
    step();
    set(1, 2, 1, 0, 0, 0, 0, 0, 0);
    chk("post_flush_x2_stall", 32'(sb.stall), 0);
    chk("post_flush_pending", 32'(sb.pending_cnt), 1);
    step();
    set(1, 4, 1, 0, 0, 0, 0, 0, 0);
    chk("old_x4_survives", 32'(sb.stall), 1);
    step();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("x4_drained", 32'(sb.pending_cnt), 0);
    set(1, 0, 0, 0, 0, 31, 1, 5, 0);
    chk("x31_wr_stall", 32'(sb.stall), 0);
    chk("x31_wr_issue", 32'(sb.issue), 1);
    step();
    set(1, 31, 1, 31, 1, 31, 1, 0, 0);
    chk("x31_rd_stall", 32'(sb.stall), 0);
    chk("x31_pending", 32'(sb.pending_cnt), 0);
    step();
    set(1, 0, 0, 0, 0, 1, 1, 7, 0);
    step();
    set(1, 0, 0, 0, 0, 2, 1, 7, 0);
    step();
    set(1, 0, 0, 0, 0, 3, 1, 7, 0);
    step();
    set(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_pending", 32'(sb.pending_cnt), 3);
    chk("pre_rst_stall", 32'(sb.stall), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_pending", 32'(sb.pending_cnt), 0);
    chk("post_rst_stall", 32'(sb.stall), 0);
    chk("post_rst_issue", 32'(sb.issue), 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
